fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin, packet-locked arbiter sharing the async FIFO write port among NREQ requesters in the AXI-to-I2C bridge, e.g. AXI write-data, register-command and status-response sources. Lives entirely in the write clock domain. Drives the FIFO's wr_en/wdata, honours wr_full, and holds a grant until the requester's last beat. A stall watchdog reclaims the port from a requester that stops mid-packet.

## Interface
- NREQ, 4: number of requesters, 2..8
- DATASIZE, 8: FIFO data width, must match the FIFO instance
- STALL_MAX, 16: idle cycles tolerated inside a granted packet before abort, ≥1
- wr_clk  in  1  write-domain clock, same clock as the FIFO write side
- wrst_n  in  1  synchronous, active-low reset, sampled on rising wr_clk
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*DATASIZE  packed beats; requester i occupies bits [i*DATASIZE +: DATASIZE]
- req_last  in  NREQ  beat is final of packet
- req_ready  out  NREQ  beat accepted when valid&ready
- wr_full  in  1  FIFO full flag
- wr_en  out  1  FIFO write strobe
- wdata  out  DATASIZE  FIFO write data
- grant  out  NREQ  one-hot current owner; zero in IDLE
- abort  out  NREQ  one-cycle pulse, packet of requester i was cut by watchdog

## Operation
- FSM states: IDLE and LOCK.
- IDLE:
  - grant=0 and req_ready=0.
  - If any req_valid is set, pick the first valid index searching upward from last_gnt+1 (mod NREQ).
  - Register grant and gnt_idx, then go to LOCK. No beat is written in IDLE.
- LOCK, owner g:
  - req_ready[g] = ~wr_full; all other ready bits are 0.
  - wr_en = req_valid[g] & ~wr_full.
  - wdata = req_data slice g, combinational mux.
- Beat with req_last[g] accepted: last_gnt<=g, grant<=0, go to IDLE.
- Valid but blocked by wr_full: hold state; the stall counter does not advance (back-pressure is not a stall).
- req_valid[g]=0 in LOCK:
  - stall_cnt increments; any accepted beat clears it.
  - When stall_cnt reaches STALL_MAX, pulse abort[g], last_gnt<=g, go to IDLE.
  - The owner's later beats start a new packet.
- Non-owners' valid and data are ignored; their data may change freely.
- stall_cnt width is $clog2(STALL_MAX+1). The gnt_idx and last_gnt width is $clog2(NREQ), minimum 1.

## Timing
- Reset values:
  - state IDLE, grant 0, abort 0, wr_en 0, req_ready 0, stall_cnt 0.
  - last_gnt = NREQ-1, so requester 0 wins the first arbitration.
  - wdata is don't-care while wr_en=0; the mux of slice 0 is acceptable.
- Arbitration latency: valid seen in IDLE at cycle N, grant at N+1, first write at N+1 if wr_full=0.
- Throughput: one beat per cycle inside a packet. One dead IDLE cycle between packets.
- wr_full is sampled combinationally in the same cycle; no write is ever issued while wr_full=1.
- Single-beat packet (valid&last on the first LOCK cycle) occupies one LOCK cycle.
- Reset asserted mid-packet: next edge returns to reset values. A partial packet already in the FIFO is not retracted.
- abort is registered, high exactly one cycle, coincident with the IDLE entry.

## Configuration
- FIFO_ARB_TAG_EN defined:
  - adds output wr_tag, width $clog2(NREQ), = gnt_idx.
  - wr_tag is valid whenever wr_en=1, so the consumer can demultiplex by source (packaged alongside the FIFO by the integrator).
- Undefined: port and logic absent; identical behaviour otherwise.

## Structure
- Shared package fifo_arb_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_LOCK}
  - function rr_pick(valid, last) returning the next index and a found flag, reused by future arbiters.
- One sub-module, rr_priority_select: combinational rotate, find-first and unrotate, parameterised on NREQ.
- FSM, stall counter and data mux stay in the top.

## Test plan
- Reset, then req_valid=4'b1010, each a 3-beat packet -> grants 1 then 3; FIFO receives 3 beats of req1 then 3 of req3; one idle cycle between packets.
- All four requesters continuously valid, 1-beat packets -> grant order 0,1,2,3,0,…; no requester is served twice before the others.
- Owner 2 streaming; wr_full=1 for 5 cycles mid-packet -> wr_en=0 and req_ready[2]=0 for those 5 cycles; no abort; data order preserved.
- Owner 0 drops valid for STALL_MAX=16 cycles mid-packet -> abort[0] pulses on cycle 16; next arbitration favours requester 1 when valid.
- wrst_n=0 for one cycle during a 4-beat packet after beat 2 -> grant=0, wr_en=0 next cycle; requester 0 has priority afterwards.
- With FIFO_ARB_TAG_EN: owner 3 writes -> wr_tag=2'd3 on every wr_en cycle; without the macro the design compiles with no wr_tag port.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiters.
// rr_pick is a reusable round-robin search for arbiters of up to RR_MAX_REQ requesters.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_REQ = 8;
  localparam int unsigned RR_IDX_W   = 3;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

  // First valid index searching upward from last+1, wrapping modulo nreq.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX_REQ-1:0] valid,
    input logic [RR_IDX_W-1:0]   last,
    input int unsigned           nreq
  );
    rr_pick_t    res;
    int unsigned pos;
    res.found = 1'b0;
    res.idx   = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (k < nreq) begin
        pos = (32'(last) + 32'd1 + k) % nreq;
        if (!res.found && valid[pos]) begin
          res.found = 1'b1;
          res.idx   = RR_IDX_W'(pos);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: rotate the request vector so the search
// starts just above the previous winner, find the first set bit, rotate back.
module rr_priority_select
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [IW-1:0]   start;
  logic [NREQ-1:0] rotated;
  logic [IW-1:0]   offset;
  int unsigned     rot_pos;
  int unsigned     win_pos;

  // Search origin is one above the previous winner, wrapping to zero.
  always_comb begin
    if (32'(last) >= (NREQ - 32'd1)) begin
      start = '0;
    end else begin
      start = last + IW'(1'b1);
    end
  end

  // Rotate so that bit 0 of rotated is the highest-priority requester.
  always_comb begin
    rotated = '0;
    rot_pos = 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rot_pos    = 32'(start) + k;
      rot_pos    = (rot_pos >= NREQ) ? (rot_pos - NREQ) : rot_pos;
      rotated[k] = valid[rot_pos];
    end
  end

  // Find-first from the top down so the lowest set offset wins.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      found  = found | rotated[k];
      offset = rotated[k] ? IW'(k) : offset;
    end
  end

  // Undo the rotation to recover the absolute requester index.
  always_comb begin
    win_pos = 32'(start) + 32'(offset);
    win_pos = (win_pos >= NREQ) ? (win_pos - NREQ) : win_pos;
    idx     = IW'(win_pos);
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter for the async FIFO write port.
// Optional FIFO_ARB_TAG_EN adds a wr_tag output carrying the current owner index.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned STALL_MAX = 16
) (
  input  logic                     wr_clk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wr_full,
  output logic                     wr_en,
  output logic [DATASIZE-1:0]      wdata,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          abort
`ifdef FIFO_ARB_TAG_EN
  ,
  output logic [idx_width(NREQ)-1:0] wr_tag
`endif
);

  localparam int unsigned IW = idx_width(NREQ);
  localparam int unsigned CW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] STALL_LIMIT = CW'(STALL_MAX);

  arb_state_t      state;
  arb_state_t      next_state;
  logic [NREQ-1:0] next_grant;
  logic [NREQ-1:0] next_abort;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   next_gnt_idx;
  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   next_last_gnt;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   next_stall_cnt;
  logic [CW-1:0]   stall_inc;
  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic            in_lock;
  logic            owner_valid;
  logic            owner_last;
  logic            accept;

  rr_priority_select #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_select (
    .valid (req_valid),
    .last  (last_gnt),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign in_lock     = (state == ARB_LOCK);
  assign owner_valid = req_valid[gnt_idx];
  assign owner_last  = req_last[gnt_idx];
  assign accept      = in_lock & owner_valid & ~wr_full;
  assign stall_inc   = stall_cnt + CW'(1'b1);

  // wr_full gates the strobe in the same cycle, so a full FIFO is never written.
  always_comb begin
    req_ready = '0;
    wr_en     = 1'b0;
    if (in_lock) begin
      req_ready[gnt_idx] = ~wr_full;
      wr_en              = owner_valid & ~wr_full;
    end else begin
      req_ready = '0;
      wr_en     = 1'b0;
    end
  end

  assign wdata = req_data[32'(gnt_idx)*DATASIZE +: DATASIZE];

`ifdef FIFO_ARB_TAG_EN
  assign wr_tag = gnt_idx;
`endif

  // Next-state logic: arbitrate in IDLE, hold the port in LOCK until last beat or stall timeout.
  always_comb begin
    next_state     = state;
    next_grant     = grant;
    next_gnt_idx   = gnt_idx;
    next_last_gnt  = last_gnt;
    next_stall_cnt = stall_cnt;
    next_abort     = '0;
    case (state)
      ARB_IDLE: begin
        next_stall_cnt = '0;
        if (sel_found) begin
          next_state   = ARB_LOCK;
          next_grant   = NREQ'(1'b1) << sel_idx;
          next_gnt_idx = sel_idx;
        end else begin
          next_state = ARB_IDLE;
          next_grant = '0;
        end
      end
      ARB_LOCK: begin
        if (accept) begin
          next_stall_cnt = '0;
          if (owner_last) begin
            next_state    = ARB_IDLE;
            next_grant    = '0;
            next_last_gnt = gnt_idx;
          end else begin
            next_state = ARB_LOCK;
          end
        end else if (!owner_valid) begin
          // The owner went quiet mid-packet; reclaim the port after STALL_MAX idle cycles.
          if (stall_inc == STALL_LIMIT) begin
            next_state     = ARB_IDLE;
            next_grant     = '0;
            next_last_gnt  = gnt_idx;
            next_stall_cnt = '0;
            next_abort     = grant;
          end else begin
            next_stall_cnt = stall_inc;
          end
        end else begin
          next_stall_cnt = stall_cnt;
        end
      end
      default: begin
        next_state     = ARB_IDLE;
        next_grant     = '0;
        next_stall_cnt = '0;
      end
    endcase
  end

  // State and registered outputs; last_gnt resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge wr_clk) begin
    if (!wrst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      gnt_idx   <= '0;
      last_gnt  <= IW'(NREQ - 32'd1);
      stall_cnt <= '0;
      abort     <= '0;
    end else begin
      state     <= next_state;
      grant     <= next_grant;
      gnt_idx   <= next_gnt_idx;
      last_gnt  <= next_last_gnt;
      stall_cnt <= next_stall_cnt;
      abort     <= next_abort;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-requester beat queues feed the DUT,
// expected FIFO writes and grant order are queued up front and popped as the DUT writes.
module tb_fifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int SMAX = 16;

  logic               wr_clk = 1'b0;
  logic               wrst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               wr_full;
  logic               wr_en;
  logic [DW-1:0]      wdata;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    abort;
`ifdef FIFO_ARB_TAG_EN
  logic [1:0]         wr_tag;
`endif

  always #5 wr_clk = ~wr_clk;

  fifo_write_arbiter #(
    .NREQ      (NREQ),
    .DATASIZE  (DW),
    .STALL_MAX (SMAX)
  ) dut (
    .wr_clk    (wr_clk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wr_full   (wr_full),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .grant     (grant),
    .abort     (abort)
`ifdef FIFO_ARB_TAG_EN
    ,
    .wr_tag    (wr_tag)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]      src_q[NREQ][$];
  logic [9:0]      exp_q[$];
  int              gnt_exp[$];
  logic [NREQ-1:0] en;
  logic [NREQ-1:0] s_grant;
  logic [NREQ-1:0] s_abort;
  logic [NREQ-1:0] s_ready;
  logic            s_wr_en;
  logic [NREQ-1:0] prev_grant;
  logic [NREQ-1:0] abort_acc;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src_q[i][0][7:0];
        req_last[i]           = src_q[i][0][8];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = 8'($urandom);
        req_last[i]           = 1'($urandom);
      end
    end
  endtask

  task automatic push_beat(input int src, input logic [7:0] d, input logic last);
    src_q[src].push_back({last, d});
    exp_q.push_back({2'(src), d});
  endtask

  task automatic step();
    logic [NREQ-1:0] acc;
    logic [9:0]      e;
    int              g;
    @(negedge wr_clk);
    s_grant   = grant;
    s_abort   = abort;
    s_ready   = req_ready;
    s_wr_en   = wr_en;
    abort_acc = abort_acc | abort;
    acc       = req_valid & req_ready;
    if (wr_full) begin
      checks++;
      if (wr_en !== 1'b0) begin
        errors++;
        $display("FAIL write_while_full: wr_en=%b required 0", wr_en);
      end
    end
    if (grant !== 4'b0000 && prev_grant === 4'b0000) begin
      checks++;
      if (gnt_exp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: grant=%b required none", grant);
      end else begin
        g = gnt_exp.pop_front();
        if (grant !== 4'(1 << g)) begin
          errors++;
          $display("FAIL grant_order: grant=%b required %b", grant, 4'(1 << g));
        end
      end
    end
    prev_grant = grant;
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: wdata=%h", wdata);
      end else begin
        e = exp_q.pop_front();
        if (wdata !== e[7:0] || grant !== (4'b0001 << e[9:8])) begin
          errors++;
          $display("FAIL fifo_write: wdata=%h grant=%b required wdata=%h grant=%b",
                   wdata, grant, e[7:0], 4'b0001 << e[9:8]);
        end
`ifdef FIFO_ARB_TAG_EN
        if (wr_tag !== e[9:8]) begin
          errors++;
          $display("FAIL wr_tag: wr_tag=%0d required %0d", wr_tag, e[9:8]);
        end
`endif
      end
    end
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic run_until_empty(input int max, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d writes pending after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    wrst_n  = 1'b0;
    wr_full = 1'b0;
    en      = '1;
    drive();
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    checks += 4;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: %b required 0000", grant); end
    if (abort !== 4'b0000) begin errors++; $display("FAIL reset_abort: %b required 0000", abort); end
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: %b required 0", wr_en); end
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: %b required 0000", req_ready); end
    @(posedge wr_clk);
    #1;
    wrst_n     = 1'b1;
    prev_grant = '0;
  endtask

  task automatic test_two_packets();
    int n;
    for (int b = 0; b < 3; b++) push_beat(1, 8'(8'h10 + b), b == 2);
    for (int b = 0; b < 3; b++) push_beat(3, 8'(8'h30 + b), b == 2);
    gnt_exp.push_back(1);
    gnt_exp.push_back(3);
    drive();
    run_until_empty(20, n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL two_packet_cycles: %0d required 8", n); end
  endtask

  task automatic test_round_robin();
    int n;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        push_beat(i, 8'(8'h40 + r*4 + i), 1'b1);
        gnt_exp.push_back(i);
      end
    end
    drive();
    run_until_empty(60, n);
    checks++;
    if (n != 24) begin errors++; $display("FAIL rr_cycles: %0d required 24", n); end
  endtask

  task automatic test_backpressure();
    int n;
    for (int b = 0; b < 6; b++) push_beat(2, 8'(8'h80 + b), b == 5);
    gnt_exp.push_back(2);
    abort_acc = '0;
    drive();
    repeat (3) step();
    wr_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (s_wr_en !== 1'b0 || s_ready[2] !== 1'b0) begin
        errors++;
        $display("FAIL full_stall: wr_en=%b ready2=%b required 0 0", s_wr_en, s_ready[2]);
      end
    end
    wr_full = 1'b0;
    run_until_empty(10, n);
    checks += 2;
    if (n != 4) begin errors++; $display("FAIL full_resume: %0d cycles required 4", n); end
    if (abort_acc !== 4'b0000) begin errors++; $display("FAIL full_abort: %b required 0000", abort_acc); end
  endtask

  task automatic test_stall();
    int n;
    for (int b = 0; b < 2; b++) push_beat(0, 8'(8'hA0 + b), 1'b0);
    push_beat(1, 8'hB0, 1'b1);
    // Beats 2..4 of requester 0 form a fresh packet after the abort, behind requester 1.
    for (int b = 2; b < 5; b++) push_beat(0, 8'(8'hA0 + b), b == 4);
    gnt_exp.push_back(0);
    gnt_exp.push_back(1);
    gnt_exp.push_back(0);
    en[0] = 1'b1;
    en[1] = 1'b1;
    drive();
    repeat (3) step();
    en[0]     = 1'b0;
    abort_acc = '0;
    drive();
    repeat (SMAX) step();
    checks++;
    if (abort_acc !== 4'b0000) begin errors++; $display("FAIL abort_early: %b required 0000", abort_acc); end
    en[0] = 1'b1;
    drive();
    step();
    checks += 2;
    if (s_abort !== 4'b0001) begin errors++; $display("FAIL abort_pulse: %b required 0001", s_abort); end
    if (s_grant !== 4'b0000) begin errors++; $display("FAIL abort_idle: grant=%b required 0000", s_grant); end
    step();
    checks++;
    if (s_abort !== 4'b0000) begin errors++; $display("FAIL abort_width: %b required 0000", s_abort); end
    run_until_empty(20, n);
  endtask

  task automatic test_reset_mid();
    int n;
    for (int b = 0; b < 2; b++) push_beat(0, 8'(8'hC0 + b), 1'b0);
    for (int b = 2; b < 4; b++) push_beat(0, 8'(8'hC0 + b), b == 3);
    gnt_exp.push_back(0);
    gnt_exp.push_back(0);
    gnt_exp.push_back(1);
    drive();
    repeat (3) step();
    wrst_n = 1'b0;
    en[0]  = 1'b0;
    drive();
    step();
    wrst_n = 1'b1;
    en[0]  = 1'b1;
    push_beat(1, 8'hD0, 1'b1);
    drive();
    step();
    checks += 3;
    if (s_grant !== 4'b0000) begin errors++; $display("FAIL rst_mid_grant: %b required 0000", s_grant); end
    if (s_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en: %b required 0", s_wr_en); end
    if (s_abort !== 4'b0000) begin errors++; $display("FAIL rst_mid_abort: %b required 0000", s_abort); end
    run_until_empty(20, n);
  endtask

  task automatic test_tag();
    int n;
    for (int b = 0; b < 3; b++) push_beat(3, 8'(8'hE0 + b), b == 2);
    gnt_exp.push_back(3);
    drive();
    run_until_empty(10, n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL tag_cycles: %0d required 4", n); end
  endtask

  initial begin
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    wr_full    = 1'b0;
    en         = '1;
    prev_grant = '0;
    abort_acc  = '0;
    test_reset();
    test_two_packets();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_tag();
    checks++;
    if (gnt_exp.size() != 0) begin
      errors++;
      $display("FAIL leftover_grants: %0d pending required 0", gnt_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
